// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundle of the fetch, load/store and memory-bus signals shared
//             between the pipeline stages, the arbiter and the memory.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
    // Instruction-fetch side
    logic        InstrReq;
    logic [15:0] InstrAddr;
    logic [31:0] InstrData;
    logic        InstrReady;
    // Load/store side
    logic        DataRead;
    logic        DataWrite;
    logic [15:0] DataAddr;
    logic [31:0] DataWData;
    logic [31:0] DataRData;
    logic        DataReady;
    // External memory bus
    logic [15:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemRData;
    // Pipeline-wide stall
    logic        Stall;

    // Arbiter view
    modport slave (
        input  InstrReq, InstrAddr, DataRead, DataWrite, DataAddr, DataWData, MemRData,
        output InstrData, InstrReady, DataRData, DataReady,
               MemAddr, MemWData, MemRead, MemWrite, Stall
    );

    // Pipeline / memory-model view
    modport master (
        output InstrReq, InstrAddr, DataRead, DataWrite, DataAddr, DataWData, MemRData,
        input  InstrData, InstrReady, DataRData, DataReady,
               MemAddr, MemWData, MemRead, MemWrite, Stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-ported memory between instruction fetch and
//             load/store. Round-robin arbitration in IDLE, WAIT_STATES+1 bus
//             cycles per access, one-cycle Ready pulses, combinational Stall.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_data_q, last_data_d;   // 1: data was served last
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      instr_data_q, instr_data_d;
    logic [31:0]      data_rdata_q, data_rdata_d;
    logic             instr_ready_q, instr_ready_d;
    logic             data_ready_q, data_ready_d;

    // A requester whose Ready is high this cycle is masked so it cannot be
    // re-granted before it has had a chance to update its request.
    logic w_data_req;
    logic w_instr_pend;
    logic w_data_pend;
    logic w_grant_data;
    logic w_grant_instr;

    assign w_data_req    = bus.DataRead | bus.DataWrite;
    assign w_instr_pend  = bus.InstrReq & ~instr_ready_q;
    assign w_data_pend   = w_data_req & ~data_ready_q;
    assign w_grant_data  = w_data_pend & (~w_instr_pend | ~last_data_q);
    assign w_grant_instr = w_instr_pend & ~w_grant_data;

    // State register and all datapath registers; reset aborts any access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_data_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            instr_data_q  <= '0;
            data_rdata_q  <= '0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_data_q   <= last_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            instr_data_q  <= instr_data_d;
            data_rdata_q  <= data_rdata_d;
            instr_ready_q <= instr_ready_d;
            data_ready_q  <= data_ready_d;
        end
    end

    // Next-state logic: grant in IDLE, count down wait states, complete access.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_data_d   = last_data_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        instr_data_d  = instr_data_q;
        data_rdata_d  = data_rdata_q;
        instr_ready_d = 1'b0;
        data_ready_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_grant_data) begin
                    state_d     = S_DACC;
                    cnt_d       = C_CNT_LOAD;
                    mem_addr_d  = bus.DataAddr;
                    mem_wdata_d = bus.DataWData;
                    // Read and write together is treated as a store.
                    mem_write_d = bus.DataWrite;
                    mem_read_d  = ~bus.DataWrite;
                end else if (w_grant_instr) begin
                    state_d     = S_IACC;
                    cnt_d       = C_CNT_LOAD;
                    mem_addr_d  = bus.InstrAddr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end
            S_IACC, S_DACC: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == S_IACC) begin
                        instr_data_d  = bus.MemRData;
                        instr_ready_d = 1'b1;
                        last_data_d   = 1'b0;
                    end else begin
                        if (!mem_write_q) begin
                            data_rdata_d = bus.MemRData;
                        end
                        data_ready_d = 1'b1;
                        last_data_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.MemAddr    = mem_addr_q;
    assign bus.MemWData   = mem_wdata_q;
    assign bus.MemRead    = mem_read_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.InstrData  = instr_data_q;
    assign bus.DataRData  = data_rdata_q;
    assign bus.InstrReady = instr_ready_q;
    assign bus.DataReady  = data_ready_q;
    assign bus.Stall      = (bus.InstrReq & ~instr_ready_q) | (w_data_req & ~data_ready_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed bench for mem_port_arbiter with three instances
//             (WAIT_STATES = 0, 1, 3) sharing clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.WAIT_STATES(0)) u_w0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    mem_port_arbiter #(.WAIT_STATES(1)) u_w1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    mem_port_arbiter #(.WAIT_STATES(3)) u_w3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        b0.InstrReq = 0; b0.InstrAddr = 0; b0.DataRead = 0; b0.DataWrite = 0;
        b0.DataAddr = 0; b0.DataWData = 0; b0.MemRData = 0;
        b1.InstrReq = 0; b1.InstrAddr = 0; b1.DataRead = 0; b1.DataWrite = 0;
        b1.DataAddr = 0; b1.DataWData = 0; b1.MemRData = 0;
        b3.InstrReq = 0; b3.InstrAddr = 0; b3.DataRead = 0; b3.DataWrite = 0;
        b3.DataAddr = 0; b3.DataWData = 0; b3.MemRData = 0;

        // ---------------- Reset with both requests high (W=1) ----------------
        b1.InstrReq = 1; b1.InstrAddr = 16'h0040;
        b1.DataRead = 1; b1.DataAddr  = 16'h0080;
        tick(); tick();
        check("rst_memread",   b1.MemRead,    0);
        check("rst_memwrite",  b1.MemWrite,   0);
        check("rst_memaddr",   b1.MemAddr,    0);
        check("rst_memwdata",  b1.MemWData,   0);
        check("rst_iready",    b1.InstrReady, 0);
        check("rst_dready",    b1.DataReady,  0);
        check("rst_idata",     b1.InstrData,  0);
        check("rst_drdata",    b1.DataRData,  0);
        rst = 1'b0;
        #1;
        check("rst_fall_nostrobe", b1.MemRead, 0);
        tick();
        check("rst_after_read", b1.MemRead, 1);
        check("rst_after_addr", b1.MemAddr, 32'h0080);
        // Abort that access and return everything to idle.
        b1.InstrReq = 0; b1.DataRead = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort_read", b1.MemRead, 0);
        check("rst_abort_dready", b1.DataReady, 0);
        tick();

        // ---------------- Single fetch, W=1 ----------------
        b1.InstrReq = 1; b1.InstrAddr = 16'h0010; b1.MemRData = 32'hDEADBEEF;
        #1;
        check("f1_stall_t0", b1.Stall, 1);
        check("f1_read_t0",  b1.MemRead, 0);
        tick();
        check("f1_read_t1",  b1.MemRead, 1);
        check("f1_addr_t1",  b1.MemAddr, 32'h0010);
        check("f1_stall_t1", b1.Stall, 1);
        check("f1_rdy_t1",   b1.InstrReady, 0);
        tick();
        check("f1_read_t2",  b1.MemRead, 1);
        check("f1_addr_t2",  b1.MemAddr, 32'h0010);
        check("f1_rdy_t2",   b1.InstrReady, 0);
        tick();
        check("f1_rdy_t3",   b1.InstrReady, 1);
        check("f1_data_t3",  b1.InstrData, 32'hDEADBEEF);
        check("f1_read_t3",  b1.MemRead, 0);
        check("f1_stall_t3", b1.Stall, 0);
        b1.InstrReq = 0; b1.MemRData = 32'h0;
        tick();
        check("f1_rdy_t4",   b1.InstrReady, 0);
        check("f1_hold_t4",  b1.InstrData, 32'hDEADBEEF);
        check("f1_read_t4",  b1.MemRead, 0);

        // ---------------- Conflict after reset, W=0 ----------------
        b0.InstrReq = 1; b0.InstrAddr = 16'h0020;
        b0.DataRead = 1; b0.DataAddr  = 16'h0030;
        b0.MemRData = 32'hA5A50001;
        tick();
        check("cf_read_t1",  b0.MemRead, 1);
        check("cf_addr_t1",  b0.MemAddr, 32'h0030);
        tick();
        check("cf_dready_t2", b0.DataReady, 1);
        check("cf_drdata_t2", b0.DataRData, 32'hA5A50001);
        check("cf_iready_t2", b0.InstrReady, 0);
        check("cf_read_t2",   b0.MemRead, 0);
        b0.DataRead = 0; b0.MemRData = 32'h5A5A0002;
        tick();
        check("cf_read_t3",   b0.MemRead, 1);
        check("cf_addr_t3",   b0.MemAddr, 32'h0020);
        check("cf_dready_t3", b0.DataReady, 0);
        tick();
        check("cf_iready_t4", b0.InstrReady, 1);
        check("cf_idata_t4",  b0.InstrData, 32'h5A5A0002);
        check("cf_dready_t4", b0.DataReady, 0);
        b0.InstrReq = 0;
        tick();
        check("cf_idle_read", b0.MemRead, 0);

        // ---------------- Round-robin, W=0: D,I,D,I,D,I ----------------
        b0.InstrReq = 1; b0.InstrAddr = 16'h0200;
        b0.DataRead = 1; b0.DataAddr  = 16'h0300;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_read", b0.MemRead, 1);
            check("rr_addr", b0.MemAddr, (k % 2 == 0) ? 32'h0300 : 32'h0200);
            tick();
            check("rr_dready", b0.DataReady,  (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_iready", b0.InstrReady, (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 5) begin
                b0.InstrReq = 0; b0.DataRead = 0;
            end
        end
        tick();
        check("rr_end_read", b0.MemRead, 0);

        // ---------------- Store, W=3 ----------------
        b3.DataWrite = 1; b3.DataAddr = 16'h0100; b3.DataWData = 32'h12345678;
        b3.MemRData  = 32'hFFFFFFFF;
        tick();
        b3.DataWData = 32'h0;   // store data must already be latched
        for (int k = 0; k < 4; k++) begin
            check("st_write",  b3.MemWrite, 1);
            check("st_read",   b3.MemRead,  0);
            check("st_addr",   b3.MemAddr,  32'h0100);
            check("st_wdata",  b3.MemWData, 32'h12345678);
            check("st_dready", b3.DataReady, 0);
            tick();
        end
        check("st_dready_pulse", b3.DataReady, 1);
        check("st_write_done",   b3.MemWrite, 0);
        check("st_rdata_kept",   b3.DataRData, 32'h0);
        b3.DataWrite = 0;
        tick();
        check("st_dready_end", b3.DataReady, 0);

        // ---------------- Reset mid-access, W=3 ----------------
        b3.DataWrite = 1; b3.DataAddr = 16'h0104; b3.DataWData = 32'hCAFEF00D;
        tick();
        check("rm_write_c1", b3.MemWrite, 1);
        b3.InstrReq = 1; b3.InstrAddr = 16'h0044; b3.MemRData = 32'h0BADF00D;
        tick();
        check("rm_write_c2", b3.MemWrite, 1);
        rst = 1'b1; b3.DataWrite = 0;
        tick();
        rst = 1'b0;
        check("rm_write_abort", b3.MemWrite, 0);
        check("rm_read_abort",  b3.MemRead,  0);
        check("rm_dready_none", b3.DataReady, 0);
        tick();
        check("rm_igrant_read", b3.MemRead, 1);
        check("rm_igrant_addr", b3.MemAddr, 32'h0044);
        check("rm_dready_none2", b3.DataReady, 0);
        tick(); tick(); tick();
        check("rm_read_last", b3.MemRead, 1);
        tick();
        check("rm_iready",   b3.InstrReady, 1);
        check("rm_idata",    b3.InstrData, 32'h0BADF00D);
        check("rm_dready_none3", b3.DataReady, 0);
        b3.InstrReq = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
